// File: rtl/sdi_pkg.sv
// Shared SDI constants and types: TRS preamble words, XY bit positions, TRS FSM states.
package sdi_pkg;

  localparam logic [7:0] TRS_ONES = 8'hFF;
  localparam logic [7:0] TRS_ZERO = 8'h00;

  // Position of the F/V/H flags inside the 8-bit XY word
  localparam int XY_F = 6;
  localparam int XY_V = 5;
  localparam int XY_H = 4;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    GOT_FF  = 2'd1,
    GOT_00A = 2'd2,
    GOT_00B = 2'd3
  } trs_state_t;

endpackage

// File: rtl/trs_xy_check.sv
// Combinational BT.656 XY word decode: extracts F/V/H and checks the protection bits.
module trs_xy_check
  import sdi_pkg::*;
(
  input  logic [7:0] xy,
  output logic       valid,
  output logic       f,
  output logic       v,
  output logic       h
);

  // Flags come straight from the word; protection bits must match their XOR terms
  always_comb begin
    f     = xy[XY_F];
    v     = xy[XY_V];
    h     = xy[XY_H];
    valid = xy[7]
          & (xy[3] == (v ^ h))
          & (xy[2] == (f ^ h))
          & (xy[1] == (f ^ v))
          & (xy[0] == (f ^ v ^ h));
  end

endmodule

// File: rtl/sdi_trs_decoder.sv
// BT.656 TRS decoder: finds FF 00 00 XY, produces sync/field strobes, delays video by 4 words
// so sync edges align with the first TRS word out, and tracks lock via EAV/SAV alternation
// plus a TRS-gap watchdog.
module sdi_trs_decoder
  import sdi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_GAP    = 4096,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              de_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              field_o,
  output logic              eav_o,
  output logic              sav_o,
  output logic              trs_err_o,
  output logic              locked_o
);

  localparam int GAP_W = $clog2(MAX_GAP + 1);
  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  trs_state_t                 state;
  logic [3:0][DATA_W-1:0]     dly;
  logic                       f_r, v_r, h_r;
  logic [2:0]                 blank_cnt;
  logic [CNT_W-1:0]           good_cnt, cnt_nxt;
  logic [GAP_W-1:0]           gap_cnt;
  logic                       locked_r, lock_nxt;
  logic                       eav_r, sav_r, err_r;

  logic xy_valid, xy_f, xy_v, xy_h;
  logic is_ones, is_zero, good, bad, gap_hit;

  // XY sits in the top 8 bits so wider (10-bit) streams decode the same way
  trs_xy_check u_xy (
    .xy    (data_i[DATA_W-1 -: 8]),
    .valid (xy_valid),
    .f     (xy_f),
    .v     (xy_v),
    .h     (xy_h)
  );

  assign is_ones = &data_i;
  assign is_zero = ~|data_i;
  assign good    = (state == GOT_00B) &  xy_valid;
  assign bad     = (state == GOT_00B) & ~xy_valid;
  // Fires once, on the clock the gap counter steps onto MAX_GAP
  assign gap_hit = ~good & (gap_cnt == GAP_W'(MAX_GAP - 1));

  // Next lock count / lock state: alternating H counts up, repeated H restarts at 1
  always_comb begin
    cnt_nxt  = good_cnt;
    lock_nxt = locked_r;
    if (good) begin
      if (xy_h != h_r)
        cnt_nxt = (good_cnt == CNT_W'(LOCK_COUNT)) ? good_cnt : good_cnt + 1'b1;
      else
        cnt_nxt = CNT_W'(1);
      if (cnt_nxt >= CNT_W'(LOCK_COUNT))
        lock_nxt = 1'b1;
    end else if (bad || gap_hit) begin
      cnt_nxt  = '0;
      lock_nxt = 1'b0;
    end
  end

  // TRS preamble search; an all-ones word always restarts the match
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state <= SEEK;
    end else if (is_ones) begin
      state <= GOT_FF;
    end else begin
      case (state)
        GOT_FF:  state <= is_zero ? GOT_00A : SEEK;
        GOT_00A: state <= is_zero ? GOT_00B : SEEK;
        default: state <= SEEK;
      endcase
    end
  end

  // 4-word video delay so data_o shows the FF preamble when the TRS decode lands
  always_ff @(posedge pix_clk) begin
    if (rst) dly <= '0;
    else     dly <= {dly[2:0], data_i};
  end

  // Sync flags, strobes, blanking/lock/gap counters
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      f_r       <= 1'b0;
      v_r       <= 1'b0;
      h_r       <= 1'b0;
      blank_cnt <= '0;
      good_cnt  <= '0;
      gap_cnt   <= '0;
      locked_r  <= 1'b0;
      eav_r     <= 1'b0;
      sav_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      eav_r    <= good &  xy_h;
      sav_r    <= good & ~xy_h;
      err_r    <= bad;
      good_cnt <= cnt_nxt;
      locked_r <= lock_nxt;
      if (good) begin
        f_r       <= xy_f;
        v_r       <= xy_v;
        h_r       <= xy_h;
        blank_cnt <= 3'd4;
        gap_cnt   <= '0;
      end else begin
        if (blank_cnt != 3'd0)                 blank_cnt <= blank_cnt - 3'd1;
        if (gap_cnt != GAP_W'(MAX_GAP))        gap_cnt   <= gap_cnt + 1'b1;
      end
    end
  end

  assign data_o    = dly[3];
  assign de_o      = locked_r & ~h_r & ~v_r & (blank_cnt == 3'd0);
  assign hsync_o   = SYNC_POL ? h_r : ~h_r;
  assign vsync_o   = SYNC_POL ? v_r : ~v_r;
  assign field_o   = f_r;
  assign eav_o     = eav_r;
  assign sav_o     = sav_r;
  assign trs_err_o = err_r;
  assign locked_o  = locked_r;

endmodule
